snake_tile_renderer: RTL and testbench
======================================

Name: snake_tile_renderer

Overview:
- Parametrised successor to the two-snake VGA compositor.
- Supports NUM_SNAKES snakes and NUM_FOOD food items on a configurable GRID_W x GRID_H grid of TILE-pixel tiles.
- Replaces per-segment sprite ROMs and comparators with a tile-code map. A state machine rebuilds the map during vertical blanking, so frames never tear.
- Sits between the game core, the external image/sprite ROM IP cores, and vgac. It drives vgac's Din.

Parameters:
- NUM_SNAKES, 2, number of snakes (1..4)
- MAX_LEN, 31, segments per snake bus
- NUM_FOOD, 2, food items
- GRID_W, 32, tiles per row
- GRID_H, 24, tiles per column
- TILE, 20, tile edge in pixels
- POS_W, 10, position width; pos = tile_row*GRID_W + tile_col
- TRANSPARENT, 12'hFFF, sprite colour treated as see-through

Ports:
- vga_clk  in  1  pixel clock
- vga_rst  in  1  synchronous active-high reset
- row_addr  in  10  current pixel row from vgac
- col_addr  in  10  current pixel column from vgac
- frame_start  in  1  one-cycle pulse at start of vertical blank
- mode  in  2  00 menu, 01 play, 10 game over, 11 pause
- snakes  in  NUM_SNAKES*MAX_LEN*POS_W  segment positions; segment 0 is the head
- lengths  in  NUM_SNAKES*5  live segment count per snake
- foods  in  NUM_FOOD*POS_W  food positions
- bg_addr  out  19  address to menu/background/game-over ROMs
- menu_data, bg_data, over_data  in  12 each  ROM outputs (1-cycle read latency)
- spr_addr  out  SPR_AW  combined sprite ROM address
- spr_data  in  12  sprite ROM output (1-cycle read latency)
- vga_data  out  12  pixel to vgac Din
- busy  out  1  map rebuild in progress

Behaviour:
- Tile codes: 0 empty; 1 food; 2+2k head of snake k; 3+2k body of snake k.
  - CODE_W = clog2(2+2*NUM_SNAKES).
  - The sprite for code c occupies sprite ROM words (c-1)*TILE*TILE upward.
- Map: GRID_W*GRID_H x CODE_W RAM. Registered read port; write port driven only by the FSM.
- FSM states: IDLE, CLEAR, FOOD, SNAKE, and back to IDLE.
  - IDLE to CLEAR: on frame_start when mode is 01 or 10. frame_start in mode 00 or 11 is ignored, so the map freezes.
  - CLEAR: write 0 to each address 0..GRID_W*GRID_H-1, one per cycle.
  - FOOD: write code 1 at each food position, index 0 upward, one per cycle.
  - SNAKE: for k = 0..NUM_SNAKES-1, j = MAX_LEN-1 down to 0, one cycle per (k,j). Write the head or body code at segment j's position.
  - SNAKE write is suppressed when j >= lengths[k], when pos is all-ones, or when pos >= GRID_W*GRID_H.
  - Resulting priority: later writes win. Heads win over bodies, higher k wins over lower k, and snakes win over food.
  - After the last (k,j), return to IDLE.
- busy = 1 in every state except IDLE.
- Inputs are sampled live while the FSM runs. The core must hold snakes, lengths and foods stable during blanking.
- frame_start while busy is ignored.
- Rebuild length: GRID_W*GRID_H + NUM_FOOD + NUM_SNAKES*MAX_LEN cycles (832 at defaults). This is well inside blanking.
- Display pipeline, fixed latency 4 from row_addr/col_addr to vga_data; runs in all modes:
  - S1: tile_r = row/TILE, tile_c = col/TILE, yoff = row%TILE, xoff = col%TILE. in_screen = row < GRID_H*TILE and col < GRID_W*TILE. Map read address = tile_r*GRID_W + tile_c.
  - S2: code available from the map. Read returns 0 while busy (no stale mid-rebuild data).
  - S3: register spr_addr = (code-1)*TILE*TILE + (TILE-1-yoff)*TILE + xoff (0 if code is 0). Register bg_addr = (GRID_H*TILE-1-row)*(GRID_W*TILE) + col (0 if not in_screen).
  - S4: select vga_data.
    - Not in_screen: 0.
    - Mode 00: menu_data. Mode 10: over_data.
    - Mode 01 or 11: spr_data if code != 0 and spr_data != TRANSPARENT; otherwise bg_data.
- Row/col/in_screen/code/mode are delayed alongside the ROM reads, so all S4 operands belong to the same pixel.
- Reset: FSM to IDLE, busy = 0, vga_data = 0, bg_addr = 0, spr_addr = 0, pipeline valid bits cleared.
  - The map contents are undefined after reset and are treated as all-0 until the first rebuild completes. A clear-done flag gates reads.
  - Reset mid-rebuild aborts the rebuild and clears the clear-done flag.

Test Plan:
- Mode 00, sweep rows/cols -> vga_data equals menu_data for the same pixel 4 cycles after the address; 0 when col >= 640.
- Mode 01, snake0 length 3 at positions 33,34,35, food at 100, frame_start -> busy is high for 832 cycles.
  - Next frame: pixel (20,20) shows the head sprite (code 2, spr_addr base 400).
  - Pixels in tiles 34/35 show the body (code 3), tile 100 shows food, and all other tiles show bg_data.
- Snake0 and snake1 heads both at position 50 -> tile code is 4 (snake1 head). Segment j=3 with lengths=3 is not drawn. A position of 10'h3FF is skipped.
- Sprite pixel equal to 12'hFFF -> bg_data is shown in that pixel; an adjacent opaque pixel shows spr_data.
- Mode 11 with snake positions changed and frame_start pulsed -> busy stays 0 and the display is unchanged. Switching to mode 01 plus frame_start -> the new positions appear.
- Assert vga_rst at cycle 200 of CLEAR -> busy = 0 next cycle and vga_data = 0. Play-mode output shows only bg_data until a full rebuild completes.

Source files
------------

// File: rtl/snake_tile_renderer.sv
// Tile-map based VGA compositor for several snakes and food items.
// A small FSM rebuilds a tile-code map at the start of vertical blanking.
// A fixed four-stage pipeline turns pixel coordinates into vga_data.
module snake_tile_renderer #(
  parameter int          NUM_SNAKES  = 2,
  parameter int          MAX_LEN     = 31,
  parameter int          NUM_FOOD    = 2,
  parameter int          GRID_W      = 32,
  parameter int          GRID_H      = 24,
  parameter int          TILE        = 20,
  parameter int          POS_W       = 10,
  parameter logic [11:0] TRANSPARENT = 12'hFFF,
  parameter int          SPR_AW      = $clog2((1 + 2*NUM_SNAKES)*TILE*TILE)
) (
  input  logic                                vga_clk,
  input  logic                                vga_rst,
  input  logic [9:0]                          row_addr,
  input  logic [9:0]                          col_addr,
  input  logic                                frame_start,
  input  logic [1:0]                          mode,
  input  logic [NUM_SNAKES*MAX_LEN*POS_W-1:0] snakes,
  input  logic [NUM_SNAKES*5-1:0]             lengths,
  input  logic [NUM_FOOD*POS_W-1:0]           foods,
  output logic [18:0]                         bg_addr,
  input  logic [11:0]                         menu_data,
  input  logic [11:0]                         bg_data,
  input  logic [11:0]                         over_data,
  output logic [SPR_AW-1:0]                   spr_addr,
  input  logic [11:0]                         spr_data,
  output logic [11:0]                         vga_data,
  output logic                                busy
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int CODE_W = $clog2(2 + 2*NUM_SNAKES);
  localparam int MAP_AW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int K_W    = (NUM_SNAKES > 1) ? $clog2(NUM_SNAKES) : 1;
  localparam int J_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int F_W    = (NUM_FOOD > 1) ? $clog2(NUM_FOOD) : 1;
  localparam int OFF_W  = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int SCR_W  = GRID_W * TILE;
  localparam int SCR_H  = GRID_H * TILE;

  localparam logic [MAP_AW-1:0] LAST_CELL = MAP_AW'(CELLS - 1);
  localparam logic [MAP_AW-1:0] LAST_FOOD = MAP_AW'(NUM_FOOD - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(NUM_SNAKES - 1);
  localparam logic [J_W-1:0]    LAST_J    = J_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FOOD, SNAKE} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [MAP_AW-1:0] r_cnt;
  logic [K_W-1:0]    r_k;
  logic [J_W-1:0]    r_j;
  logic              r_clearDone;

  logic              w_we;
  logic [MAP_AW-1:0] w_wAddr;
  logic [CODE_W-1:0] w_wData;

  logic [POS_W-1:0] w_seg  [NUM_SNAKES][MAX_LEN];
  logic [4:0]       w_len  [NUM_SNAKES];
  logic [POS_W-1:0] w_food [NUM_FOOD];
  logic [POS_W-1:0] w_curSeg;
  logic [4:0]       w_curLen;
  logic [POS_W-1:0] w_curFood;

  logic [CODE_W-1:0] r_map [CELLS];
  logic [CODE_W-1:0] r_mapQ;

  // Unpack the flat game-core buses into indexable per-item views
  for (genvar gk = 0; gk < NUM_SNAKES; gk++) begin : g_snake
    assign w_len[gk] = lengths[gk*5 +: 5];
    for (genvar gj = 0; gj < MAX_LEN; gj++) begin : g_seg
      assign w_seg[gk][gj] = snakes[(gk*MAX_LEN + gj)*POS_W +: POS_W];
    end
  end
  for (genvar gf = 0; gf < NUM_FOOD; gf++) begin : g_food
    assign w_food[gf] = foods[gf*POS_W +: POS_W];
  end

  assign w_curSeg  = w_seg[r_k][r_j];
  assign w_curLen  = w_len[r_k];
  assign w_curFood = w_food[r_cnt[F_W-1:0]];
  assign busy      = (r_state != IDLE);

  function automatic logic inGrid(input logic [POS_W-1:0] p);
    return int'(p) < CELLS;
  endfunction

  // State register for the map rebuild sequencer
  always_ff @(posedge vga_clk) begin
    if (vga_rst) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Walk counters and the flag that says the map holds a complete frame
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r_cnt       <= '0;
      r_k         <= '0;
      r_j         <= LAST_J;
      r_clearDone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_k   <= '0;
          r_j   <= LAST_J;
        end
        CLEAR: r_cnt <= (w_nextState == CLEAR) ? r_cnt + MAP_AW'(1) : '0;
        FOOD:  r_cnt <= r_cnt + MAP_AW'(1);
        SNAKE: begin
          if (r_j == '0) begin
            r_j <= LAST_J;
            r_k <= r_k + K_W'(1);
          end else begin
            r_j <= r_j - J_W'(1);
          end
          if (w_nextState == IDLE) r_clearDone <= 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Next-state and map write port; later writes overwrite earlier ones
  always_comb begin
    w_nextState = r_state;
    w_we        = 1'b0;
    w_wAddr     = '0;
    w_wData     = '0;
    case (r_state)
      IDLE: begin
        if (frame_start && (mode == 2'b01 || mode == 2'b10)) w_nextState = CLEAR;
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_wAddr = r_cnt;
        if (r_cnt == LAST_CELL) w_nextState = FOOD;
      end
      FOOD: begin
        w_we    = inGrid(w_curFood);
        w_wAddr = MAP_AW'(w_curFood);
        w_wData = CODE_W'(1);
        if (r_cnt == LAST_FOOD) w_nextState = SNAKE;
      end
      SNAKE: begin
        w_we    = (int'(r_j) < int'(w_curLen)) && (w_curSeg != '1) && inGrid(w_curSeg);
        w_wAddr = MAP_AW'(w_curSeg);
        w_wData = (r_j == '0) ? CODE_W'(2 + 2*int'(r_k)) : CODE_W'(3 + 2*int'(r_k));
        if (r_k == LAST_K && r_j == '0) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // ---------------- display pipeline ----------------
  logic [9:0]        w_tileR, w_tileC, w_yoff, w_xoff;
  logic              w_inScreen;
  logic [MAP_AW-1:0] w_mapAddr;

  assign w_tileR    = row_addr / 10'(TILE);
  assign w_tileC    = col_addr / 10'(TILE);
  assign w_yoff     = row_addr % 10'(TILE);
  assign w_xoff     = col_addr % 10'(TILE);
  assign w_inScreen = (int'(row_addr) < SCR_H) && (int'(col_addr) < SCR_W);
  assign w_mapAddr  = w_inScreen ? MAP_AW'(int'(w_tileR)*GRID_W + int'(w_tileC)) : '0;

  logic              r1_valid, r1_inScreen;
  logic [9:0]        r1_row, r1_col;
  logic [OFF_W-1:0]  r1_yoff, r1_xoff;
  logic [MAP_AW-1:0] r1_mapAddr;
  logic [1:0]        r1_mode;

  logic              r2_valid, r2_inScreen, r2_gate;
  logic [9:0]        r2_row, r2_col;
  logic [OFF_W-1:0]  r2_yoff, r2_xoff;
  logic [1:0]        r2_mode;
  logic [CODE_W-1:0] w_code2;

  logic              r3_valid, r3_inScreen;
  logic [CODE_W-1:0] r3_code;
  logic [1:0]        r3_mode;
  logic [SPR_AW-1:0] r_sprAddr;
  logic [18:0]       r_bgAddr;

  logic              r4_valid, r4_inScreen;
  logic [CODE_W-1:0] r4_code;
  logic [1:0]        r4_mode;

  // Map RAM: single FSM write port, registered read for the display
  always_ff @(posedge vga_clk) begin
    if (w_we) r_map[w_wAddr] <= w_wData;
    r_mapQ <= r_map[r1_mapAddr];
  end

  // S1: split the pixel into tile index and in-tile offset
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r1_valid    <= 1'b0;
      r1_inScreen <= 1'b0;
      r1_row      <= '0;
      r1_col      <= '0;
      r1_yoff     <= '0;
      r1_xoff     <= '0;
      r1_mapAddr  <= '0;
      r1_mode     <= '0;
    end else begin
      r1_valid    <= 1'b1;
      r1_inScreen <= w_inScreen;
      r1_row      <= row_addr;
      r1_col      <= col_addr;
      r1_yoff     <= OFF_W'(w_yoff);
      r1_xoff     <= OFF_W'(w_xoff);
      r1_mapAddr  <= w_mapAddr;
      r1_mode     <= mode;
    end
  end

  // S2: carry the pixel alongside the map read; note whether the map may be read
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r2_valid    <= 1'b0;
      r2_inScreen <= 1'b0;
      r2_gate     <= 1'b1;
      r2_row      <= '0;
      r2_col      <= '0;
      r2_yoff     <= '0;
      r2_xoff     <= '0;
      r2_mode     <= '0;
    end else begin
      r2_valid    <= r1_valid;
      r2_inScreen <= r1_inScreen;
      r2_gate     <= busy || !r_clearDone;
      r2_row      <= r1_row;
      r2_col      <= r1_col;
      r2_yoff     <= r1_yoff;
      r2_xoff     <= r1_xoff;
      r2_mode     <= r1_mode;
    end
  end

  assign w_code2 = (r2_gate || !r2_inScreen) ? '0 : r_mapQ;

  // S3: form sprite and background ROM addresses (sprites are stored bottom row first)
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r3_valid    <= 1'b0;
      r3_inScreen <= 1'b0;
      r3_code     <= '0;
      r3_mode     <= '0;
      r_sprAddr   <= '0;
      r_bgAddr    <= '0;
    end else begin
      r3_valid    <= r2_valid;
      r3_inScreen <= r2_inScreen;
      r3_code     <= w_code2;
      r3_mode     <= r2_mode;
      r_sprAddr   <= (w_code2 == '0) ? '0 :
                     SPR_AW'((int'(w_code2) - 1)*TILE*TILE
                             + (TILE - 1 - int'(r2_yoff))*TILE + int'(r2_xoff));
      r_bgAddr    <= r2_inScreen ?
                     19'((SCR_H - 1 - int'(r2_row))*SCR_W + int'(r2_col)) : '0;
    end
  end

  // S4: pixel context that lines up with the ROM read data
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r4_valid    <= 1'b0;
      r4_inScreen <= 1'b0;
      r4_code     <= '0;
      r4_mode     <= '0;
    end else begin
      r4_valid    <= r3_valid;
      r4_inScreen <= r3_inScreen;
      r4_code     <= r3_code;
      r4_mode     <= r3_mode;
    end
  end

  assign spr_addr = r_sprAddr;
  assign bg_addr  = r_bgAddr;

  // Final colour select; transparent sprite pixels let the background through
  always_comb begin
    vga_data = '0;
    if (r4_valid && r4_inScreen) begin
      case (r4_mode)
        2'b00:   vga_data = menu_data;
        2'b10:   vga_data = over_data;
        default: vga_data = (r4_code != '0 && spr_data != TRANSPARENT) ? spr_data : bg_data;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Randomised bench for snake_tile_renderer with a tile-map reference model and ROM models.
module tb_snake_tile_renderer;

  localparam int NS    = 2;
  localparam int ML    = 31;
  localparam int NF    = 2;
  localparam int GW    = 32;
  localparam int GH    = 24;
  localparam int T     = 20;
  localparam int CELLS = GW*GH;
  localparam int SAW   = 12;

  logic                   vga_clk = 1'b0;
  logic                   vga_rst = 1'b1;
  logic [9:0]             row_addr = '0;
  logic [9:0]             col_addr = '0;
  logic                   frame_start = 1'b0;
  logic [1:0]             mode = 2'b00;
  logic [NS*ML*10-1:0]    snakes = '0;
  logic [NS*5-1:0]        lengths = '0;
  logic [NF*10-1:0]       foods = '0;
  logic [18:0]            bg_addr;
  logic [11:0]            menu_data = '0, bg_data = '0, over_data = '0, spr_data = '0;
  logic [SAW-1:0]         spr_addr;
  logic [11:0]            vga_data;
  logic                   busy;

  int assertions = 0;
  int failures   = 0;

  int snk [NS][ML];
  int slen [NS];
  int fd [NF];
  int mdl [CELLS];
  bit mdlValid = 0;

  int pixRow [$];
  int pixCol [$];
  logic [11:0] capGot [$];

  snake_tile_renderer dut (
    .vga_clk(vga_clk), .vga_rst(vga_rst), .row_addr(row_addr), .col_addr(col_addr),
    .frame_start(frame_start), .mode(mode), .snakes(snakes), .lengths(lengths),
    .foods(foods), .bg_addr(bg_addr), .menu_data(menu_data), .bg_data(bg_data),
    .over_data(over_data), .spr_addr(spr_addr), .spr_data(spr_data),
    .vga_data(vga_data), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM contents as simple functions of the word address
  function automatic logic [11:0] menuFn(int a); return 12'(a*37 + 11); endfunction
  function automatic logic [11:0] bgFn(int a);   return 12'(a*53 + 700); endfunction
  function automatic logic [11:0] overFn(int a); return 12'(a*29 + 5); endfunction
  function automatic logic [11:0] sprFn(int a);
    if (a % 5 == 2) return 12'hFFF;
    return {1'b0, 11'(a*13 + 1)};
  endfunction

  // External ROMs with one cycle of read latency
  always @(posedge vga_clk) begin
    menu_data <= menuFn(int'(bg_addr));
    bg_data   <= bgFn(int'(bg_addr));
    over_data <= overFn(int'(bg_addr));
    spr_data  <= sprFn(int'(spr_addr));
  end

  // Expected colour of one screen pixel from the tile map and the ROM models
  function automatic logic [11:0] expPixel(int row, int col, int md);
    int bgA, code, sa;
    logic [11:0] s;
    if (row >= GH*T || col >= GW*T) return 12'h000;
    bgA = (GH*T - 1 - row)*(GW*T) + col;
    if (md == 0) return menuFn(bgA);
    if (md == 2) return overFn(bgA);
    code = mdlValid ? mdl[(row/T)*GW + col/T] : 0;
    if (code != 0) begin
      sa = (code - 1)*T*T + (T - 1 - row%T)*T + col%T;
      s = sprFn(sa);
      if (s != 12'hFFF) return s;
    end
    return bgFn(bgA);
  endfunction

  function automatic bit segDrawn(int k, int j);
    return (j < slen[k]) && (snk[k][j] != 1023) && (snk[k][j] < CELLS);
  endfunction

  // Tile map by priority: food < (snake k bodies < snake k head) for ascending k
  task automatic buildModel();
    for (int c = 0; c < CELLS; c++) mdl[c] = 0;
    for (int f = 0; f < NF; f++) if (fd[f] < CELLS) mdl[fd[f]] = 1;
    for (int k = 0; k < NS; k++) begin
      for (int j = 1; j < ML; j++) if (segDrawn(k, j)) mdl[snk[k][j]] = 3 + 2*k;
      if (segDrawn(k, 0)) mdl[snk[k][0]] = 2 + 2*k;
    end
  endtask

  task automatic loadBuses();
    for (int k = 0; k < NS; k++) begin
      lengths[k*5 +: 5] = 5'(slen[k]);
      for (int j = 0; j < ML; j++) snakes[(k*ML + j)*10 +: 10] = 10'(snk[k][j]);
    end
    for (int f = 0; f < NF; f++) foods[f*10 +: 10] = 10'(fd[f]);
  endtask

  task automatic randomSnakes();
    for (int k = 0; k < NS; k++) begin
      slen[k] = $urandom_range(0, 31);
      for (int j = 0; j < ML; j++)
        snk[k][j] = ($urandom_range(0, 15) == 0) ? 1023 : $urandom_range(0, 799);
    end
    for (int f = 0; f < NF; f++) fd[f] = $urandom_range(0, CELLS - 1);
  endtask

  task automatic clearPix(); pixRow.delete(); pixCol.delete(); endtask
  task automatic addPix(int r, int c); pixRow.push_back(r); pixCol.push_back(c); endtask
  task automatic addRandomPix(int n);
    for (int i = 0; i < n; i++) addPix($urandom_range(0, 524), $urandom_range(0, 799));
  endtask
  task automatic addTilePix(int t, int step);
    for (int y = 0; y < T; y += step)
      for (int x = 0; x < T; x += step) addPix((t/GW)*T + y, (t%GW)*T + x);
  endtask

  // Stream the pixel list through the DUT, capturing each result four cycles later
  task automatic captureScan(input logic [1:0] md);
    int n;
    n = pixRow.size();
    capGot.delete();
    for (int i = 0; i < n + 4; i++) begin
      @(negedge vga_clk);
      if (i >= 4) capGot.push_back(vga_data);
      if (i < n) begin
        mode = md;
        row_addr = 10'(pixRow[i]);
        col_addr = 10'(pixCol[i]);
      end
    end
  endtask

  task automatic holdPixel(int r, int c, logic [1:0] md);
    @(negedge vga_clk);
    mode = md; row_addr = 10'(r); col_addr = 10'(c);
    repeat (4) @(negedge vga_clk);
  endtask

  // Pulse frame_start and count the cycles busy stays high (bounded)
  task automatic startRebuild(input logic [1:0] md, output int cycles);
    @(negedge vga_clk);
    mode = md; frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      cycles++;
      @(negedge vga_clk);
    end
  endtask

  task automatic test_reset();
    vga_rst = 1'b1;
    repeat (3) @(negedge vga_clk);
    assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    assertions++; if (vga_data !== 12'h000) begin failures++; $display("[TB] FAIL reset_vga got %h expected 000", vga_data); end
    assertions++; if (bg_addr !== 19'd0) begin failures++; $display("[TB] FAIL reset_bg_addr got %0d expected 0", bg_addr); end
    assertions++; if (spr_addr !== '0) begin failures++; $display("[TB] FAIL reset_spr_addr got %0d expected 0", spr_addr); end
    vga_rst = 1'b0;
    mdlValid = 0;
  endtask

  task automatic test_menu_and_over();
    logic [11:0] e;
    clearPix();
    addRandomPix(150);
    addPix(0, 0); addPix(0, 639); addPix(0, 640); addPix(479, 639);
    addPix(480, 0); addPix(479, 0); addPix(524, 799);
    captureScan(2'b00);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 0);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL menu_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
    captureScan(2'b10);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 2);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL over_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
  endtask

  task automatic test_rebuild_basic();
    int cycles;
    logic [11:0] e;
    randomSnakes();
    slen[0] = 3; snk[0][0] = 33; snk[0][1] = 34; snk[0][2] = 35;
    slen[1] = 0;
    fd[0] = 100; fd[1] = 100;
    loadBuses();
    @(negedge vga_clk);
    mode = 2'b01; frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      cycles++;
      frame_start = (cycles == 100);
      @(negedge vga_clk);
    end
    frame_start = 1'b0;
    assertions++;
    if (cycles != 832) begin failures++; $display("[TB] FAIL rebuild_busy_cycles got %0d expected 832", cycles); end
    repeat (3) @(negedge vga_clk);
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_retrigger got %b expected 0", busy); end
    buildModel();
    mdlValid = 1;
    holdPixel(20, 20, 2'b01);
    assertions++;
    if (spr_addr !== SAW'(780)) begin failures++; $display("[TB] FAIL head_spr_addr got %0d expected 780", spr_addr); end
    assertions++;
    if (bg_addr !== 19'd293780) begin failures++; $display("[TB] FAIL head_bg_addr got %0d expected 293780", bg_addr); end
    assertions++;
    if (vga_data !== sprFn(780)) begin failures++; $display("[TB] FAIL head_pixel got %h expected %h", vga_data, sprFn(780)); end
    clearPix();
    addTilePix(33, 1); addTilePix(34, 3); addTilePix(35, 3); addTilePix(100, 2);
    addRandomPix(200);
    captureScan(2'b01);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 1);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL basic_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
  endtask

  task automatic test_priority();
    int cycles;
    logic [11:0] e;
    randomSnakes();
    slen[0] = 3; snk[0][0] = 50; snk[0][1] = 51; snk[0][2] = 52; snk[0][3] = 53;
    slen[1] = 2; snk[1][0] = 50; snk[1][1] = 1023;
    fd[0] = 51; fd[1] = 200;
    loadBuses();
    startRebuild(2'b01, cycles);
    assertions++;
    if (cycles != 832) begin failures++; $display("[TB] FAIL priority_busy_cycles got %0d expected 832", cycles); end
    buildModel();
    mdlValid = 1;
    holdPixel(20, 360, 2'b01);
    assertions++;
    if (spr_addr !== SAW'(1580)) begin failures++; $display("[TB] FAIL shared_head_spr_addr got %0d expected 1580", spr_addr); end
    holdPixel(20, 380, 2'b01);
    assertions++;
    if (spr_addr !== SAW'(1180)) begin failures++; $display("[TB] FAIL body_over_food_spr_addr got %0d expected 1180", spr_addr); end
    holdPixel(20, 420, 2'b01);
    assertions++;
    if (spr_addr !== SAW'(0)) begin failures++; $display("[TB] FAIL beyond_length_spr_addr got %0d expected 0", spr_addr); end
    clearPix();
    addTilePix(50, 2); addTilePix(51, 4); addTilePix(53, 4); addTilePix(200, 4);
    addRandomPix(150);
    captureScan(2'b01);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 1);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL priority_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
  endtask

  task automatic test_transparency();
    logic [11:0] e;
    holdPixel(39, 362, 2'b01);
    e = bgFn(281962);
    assertions++;
    if (vga_data !== e) begin failures++; $display("[TB] FAIL transparent_pixel got %h expected %h", vga_data, e); end
    holdPixel(39, 363, 2'b01);
    e = sprFn(1203);
    assertions++;
    if (vga_data !== e) begin failures++; $display("[TB] FAIL opaque_pixel got %h expected %h", vga_data, e); end
  endtask

  task automatic test_pause_freeze();
    int cycles;
    logic [11:0] e;
    randomSnakes();
    loadBuses();
    startRebuild(2'b11, cycles);
    assertions++;
    if (cycles != 0) begin failures++; $display("[TB] FAIL pause_busy_cycles got %0d expected 0", cycles); end
    for (int i = 0; i < 5; i++) begin
      @(negedge vga_clk);
      assertions++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL pause_busy got %b expected 0", busy); end
    end
    clearPix();
    addTilePix(50, 4); addRandomPix(150);
    captureScan(2'b11);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 3);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL frozen_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
    startRebuild(2'b01, cycles);
    assertions++;
    if (cycles != 832) begin failures++; $display("[TB] FAIL resume_busy_cycles got %0d expected 832", cycles); end
    buildModel();
    captureScan(2'b01);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 1);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL resumed_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
  endtask

  task automatic test_random_frames();
    int cycles;
    logic [11:0] e;
    for (int it = 0; it < 3; it++) begin
      randomSnakes();
      loadBuses();
      startRebuild((it == 1) ? 2'b10 : 2'b01, cycles);
      assertions++;
      if (cycles != 832) begin failures++; $display("[TB] FAIL random_busy_cycles got %0d expected 832", cycles); end
      buildModel();
      clearPix();
      for (int k = 0; k < NS; k++)
        if (snk[k][0] < CELLS) addPix((snk[k][0]/GW)*T + 5, (snk[k][0]%GW)*T + 7);
      addRandomPix(250);
      captureScan(2'b01);
      for (int i = 0; i < pixRow.size(); i++) begin
        e = expPixel(pixRow[i], pixCol[i], 1);
        assertions++;
        if (capGot[i] !== e) begin
          failures++;
          $display("[TB] FAIL random_pixel it%0d (%0d,%0d) got %h expected %h", it, pixRow[i], pixCol[i], capGot[i], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cycles;
    logic [11:0] e;
    randomSnakes();
    slen[0] = 5;
    loadBuses();
    @(negedge vga_clk);
    mode = 2'b01; frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    repeat (199) @(negedge vga_clk);
    assertions++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_clear_busy got %b expected 1", busy); end
    vga_rst = 1'b1;
    @(negedge vga_clk);
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
    assertions++;
    if (vga_data !== 12'h000) begin failures++; $display("[TB] FAIL abort_vga got %h expected 000", vga_data); end
    vga_rst = 1'b0;
    mdlValid = 0;
    buildModel();
    clearPix();
    for (int j = 0; j < 5; j++)
      if (snk[0][j] < CELLS) addPix((snk[0][j]/GW)*T + 3, (snk[0][j]%GW)*T + 4);
    addRandomPix(150);
    captureScan(2'b01);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 1);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL post_abort_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
    startRebuild(2'b01, cycles);
    assertions++;
    if (cycles != 832) begin failures++; $display("[TB] FAIL post_abort_busy_cycles got %0d expected 832", cycles); end
    mdlValid = 1;
    captureScan(2'b01);
    for (int i = 0; i < pixRow.size(); i++) begin
      e = expPixel(pixRow[i], pixCol[i], 1);
      assertions++;
      if (capGot[i] !== e) begin
        failures++;
        $display("[TB] FAIL rebuilt_pixel (%0d,%0d) got %h expected %h", pixRow[i], pixCol[i], capGot[i], e);
      end
    end
  endtask

  // Safety net so the run can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired: assertions %0d failures %0d", assertions, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence
  initial begin
    for (int k = 0; k < NS; k++) begin
      slen[k] = 0;
      for (int j = 0; j < ML; j++) snk[k][j] = 1023;
    end
    for (int f = 0; f < NF; f++) fd[f] = 0;
    loadBuses();
    test_reset();
    test_menu_and_over();
    test_rebuild_basic();
    test_priority();
    test_transparency();
    test_pause_freeze();
    test_random_frames();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
